sd_spi_init_ctrl: RTL
=====================

Name: sd_spi_init_ctrl

Overview:
Parametrised SPI-mode SD card initialisation engine. It generates its own SPI clock and issues the power-up dummy clocks, then runs CMD0, CMD8 and the CMD55/ACMD41 loop. Responses are detected by polling for the R1 start bit, not by fixed cycle windows. Retries, timeouts, card-version detection and error reporting are built in. It sits between the system clock domain and the SD card pins, ahead of the block read/write engine, which waits for done.

Parameters:
CLK_DIV, 4, system clocks per SCLK half-period (min 1); SCLK = clk/(2*CLK_DIV)
POWER_ON_CYCLES, 80, SCLK cycles with CS high before CMD0 (min 74)
RESP_TIMEOUT, 8, max 0xFF-clocked bytes waiting for an R1 start bit
ACMD41_RETRIES, 1000, max CMD55/ACMD41 pairs before failing
GAP_CYCLES, 8, SCLK cycles with CS high and MOSI high between commands

Ports:
clk  in  1  system clock; the only clock
res  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse that begins initialisation
sd_miso  in  1  card data out
sd_sclk  out  1  SPI clock, idle low (mode 0)
sd_cs  out  1  chip select, active low
sd_mosi  out  1  card data in
busy  out  1  high from the start pulse until DONE or ERR
done  out  1  level; high after successful init
error  out  1  level; high after failure
err_code  out  3  0 none, 1 CMD0 timeout/bad R1, 2 CMD8 bad echo, 3 CMD55 bad R1, 4 ACMD41 retries exhausted, 5 R1 timeout elsewhere
card_v2  out  1  card accepted CMD8 (SDv2)
last_r1  out  8  most recent R1 byte received

Behaviour:
- Reset values: sd_sclk=0, sd_cs=1, sd_mosi=1, busy=0, done=0, error=0, err_code=0, card_v2=0, last_r1=8'hFF. State returns to IDLE.
- Reset asserted mid-operation aborts immediately. No partial command is completed.
- SPI mode 0: sd_mosi changes only on SCLK falling edges (or before the first rising edge); sd_miso is sampled on rising edges. Bits are sent MSB first. The divider counter runs only while busy.
- start is ignored while busy. A start in DONE or ERR clears done, error, err_code and card_v2 and restarts from POWERUP.
- States and transitions:
  - IDLE: no SCLK; on start -> POWERUP.
  - POWERUP: sd_cs=1, sd_mosi=1, POWER_ON_CYCLES SCLK cycles; then -> SEND(CMD0).
  - SEND: sd_cs=0, shift 48 bits; then -> WAIT_R1.
  - WAIT_R1: sd_mosi=1, clock bytes in; the first byte with bit7=0 is R1 and is latched to last_r1. After RESP_TIMEOUT bytes without a start bit -> ERR with the code for that command.
  - READ_EXT: 4 further bytes for R7 (CMD8 only), assembled MSB first into a 32-bit register.
  - GAP: sd_cs=1, GAP_CYCLES SCLK cycles; then -> the next SEND.
  - DONE and ERR are terminal until the next start; busy=0, SCLK stopped, sd_cs=1.
- Command frames: CMD0 = 48'h400000000095; CMD8 = 48'h48000001AA87; CMD55 = 48'h770000000065; ACMD41 = 48'h69400000_0077 if card_v2, else 48'h690000000001 (arg 0, CRC byte 8'h01 with end bit set).
- Decisions:
  - CMD0: R1 must be 8'h01, else err 1.
  - CMD8: R1 = 8'h01 and R7[11:0] = 12'h1AA -> card_v2=1. R1 with bit2 (illegal command) set -> card_v2=0, skip READ_EXT. Any other result -> err 2.
  - CMD55: R1 must be 8'h00 or 8'h01, else err 3.
  - ACMD41: R1 = 8'h00 -> DONE. R1 = 8'h01 -> increment the retry counter and loop to CMD55. When the counter reaches ACMD41_RETRIES -> err 4. Any other R1 -> err 4.
- done/error: asserted in the same cycle that busy drops; never both high.
- Retry counter width is clog2(ACMD41_RETRIES+1). The byte timeout counter is clog2(RESP_TIMEOUT+1) and restarts at every WAIT_R1 entry.

Optional Feature:
SD_OCR_READ_EN:
- Defined: after ACMD41 returns 0x00, the block sends CMD58 (48'h7A00000000FD) and reads the R3 OCR. A new output card_hc (1 bit, reset 0) takes OCR bit30. R1 other than 8'h00, or a timeout, -> err 6, and err_code stays 3 bits.
- Undefined: no CMD58 is sent, the card_hc port is absent, and DONE follows ACMD41 directly.

Test Plan:
- CLK_DIV=2, card model replies CMD0 0x01, CMD8 0x01+000001AA, CMD55 0x01, ACMD41 0x01 twice then 0x00 -> exactly 80 SCLK cycles with CS high, 3 ACMD41 frames, done=1, card_v2=1, last_r1=0x00, err_code=0.
- CMD8 replied with 0x05 -> card_v2=0, next ACMD41 frame is 48'h690000000001, and done=1 after ACMD41 returns 0x00.
- sd_miso held at 1 -> after CMD0, RESP_TIMEOUT=8 bytes are clocked, then error=1, err_code=1, sd_cs=1, busy=0.
- ACMD41_RETRIES=3, ACMD41 always returns 0x01 -> exactly 3 ACMD41 frames, then err_code=4.
- res pulsed high during the CMD8 shift -> the next clk edge shows all reset values; a following start reruns from POWERUP.
- Protocol checker throughout: sd_mosi is stable while sd_sclk is high; start pulses while busy have no effect.

Source files
------------

// File: rtl/sd_spi_init_if.sv
// SD card SPI pins plus the control/status handshake of the initialisation engine.
// With SD_OCR_READ_EN defined the bundle also carries card_hc.
interface sd_spi_init_if;
    logic       start;
    logic       sd_miso;
    logic       sd_sclk;
    logic       sd_cs;
    logic       sd_mosi;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] err_code;
    logic       card_v2;
    logic [7:0] last_r1;
`ifdef SD_OCR_READ_EN
    logic       card_hc;

    modport master (
        input  start, sd_miso,
        output sd_sclk, sd_cs, sd_mosi, busy, done, error, err_code, card_v2, last_r1, card_hc
    );
    modport slave (
        output start, sd_miso,
        input  sd_sclk, sd_cs, sd_mosi, busy, done, error, err_code, card_v2, last_r1, card_hc
    );
`else
    modport master (
        input  start, sd_miso,
        output sd_sclk, sd_cs, sd_mosi, busy, done, error, err_code, card_v2, last_r1
    );
    modport slave (
        output start, sd_miso,
        input  sd_sclk, sd_cs, sd_mosi, busy, done, error, err_code, card_v2, last_r1
    );
`endif
endinterface

// File: rtl/sd_spi_init_ctrl.sv
// SPI-mode SD card initialisation: power-up clocks, CMD0, CMD8, CMD55/ACMD41 loop.
// Define SD_OCR_READ_EN to append CMD58 and report the OCR CCS bit on card_hc.
module sd_spi_init_ctrl #(
    parameter int CLK_DIV         = 4,
    parameter int POWER_ON_CYCLES = 80,
    parameter int RESP_TIMEOUT    = 8,
    parameter int ACMD41_RETRIES  = 1000,
    parameter int GAP_CYCLES      = 8
) (
    input  logic          clk,
    input  logic          res,
    sd_spi_init_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_POWERUP, S_SEND, S_WAIT_R1, S_READ_EXT, S_GAP, S_DONE, S_ERR
    } state_e;

    typedef enum logic [2:0] {
        C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58
    } cmd_e;

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_MAX = (POWER_ON_CYCLES > GAP_CYCLES)
                           ? ((POWER_ON_CYCLES > 48) ? POWER_ON_CYCLES : 48)
                           : ((GAP_CYCLES > 48) ? GAP_CYCLES : 48);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TO_W    = $clog2(RESP_TIMEOUT + 1);
    localparam int RT_W    = $clog2(ACMD41_RETRIES + 1);
`ifdef SD_OCR_READ_EN
    localparam int EXT_W   = 31;
`else
    localparam int EXT_W   = 12;
`endif

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWER_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(47);
    localparam logic [CNT_W-1:0] EXT_LAST  = CNT_W'(31);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(RESP_TIMEOUT - 1);
    localparam logic [RT_W-1:0]  RT_LIMIT  = RT_W'(ACMD41_RETRIES);

    state_e           state_reg, state_next;
    cmd_e             cmd_reg, cmd_next;
    logic [2:0]       err_code_reg, err_code_next;
    logic             card_v2_reg, card_v2_next;
    logic [RT_W-1:0]  retry_reg, retry_next;
    logic [7:0]       last_r1_reg, last_r1_next;
`ifdef SD_OCR_READ_EN
    logic             card_hc_reg, card_hc_next;
`endif

    logic [DIV_W-1:0] div_cnt_reg;
    logic             sclk_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [TO_W-1:0]  byte_cnt_reg;
    logic [47:0]      shift_reg;
    logic [47:0]      frame_next;
    logic [7:0]       rx_reg;
    logic [EXT_W-1:0] ext_reg;

    logic busy_int, cs_int, mosi_int;
    logic tick, rise, fall;

    assign tick = busy_int && (div_cnt_reg == DIV_LAST);
    assign rise = tick && !sclk_reg;
    assign fall = tick && sclk_reg;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_reg    <= S_IDLE;
            cmd_reg      <= C_CMD0;
            err_code_reg <= 3'd0;
            card_v2_reg  <= 1'b0;
            retry_reg    <= '0;
            last_r1_reg  <= 8'hFF;
`ifdef SD_OCR_READ_EN
            card_hc_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            cmd_reg      <= cmd_next;
            err_code_reg <= err_code_next;
            card_v2_reg  <= card_v2_next;
            retry_reg    <= retry_next;
            last_r1_reg  <= last_r1_next;
`ifdef SD_OCR_READ_EN
            card_hc_reg  <= card_hc_next;
`endif
        end
    end

    // Every exit from a clocked state happens on an SCLK falling edge, so MOSI/CS never move while SCLK is high.
    always_comb begin
        state_next    = state_reg;
        cmd_next      = cmd_reg;
        err_code_next = err_code_reg;
        card_v2_next  = card_v2_reg;
        retry_next    = retry_reg;
        last_r1_next  = last_r1_reg;
`ifdef SD_OCR_READ_EN
        card_hc_next  = card_hc_reg;
`endif
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_next    = S_POWERUP;
                    cmd_next      = C_CMD0;
                    err_code_next = 3'd0;
                    card_v2_next  = 1'b0;
                    retry_next    = '0;
`ifdef SD_OCR_READ_EN
                    card_hc_next  = 1'b0;
`endif
                end
            end
            S_POWERUP: if (fall && bit_cnt_reg == PWR_LAST) state_next = S_SEND;
            S_SEND:    if (fall && bit_cnt_reg == SEND_LAST) state_next = S_WAIT_R1;
            S_WAIT_R1: begin
                if (fall && bit_cnt_reg == BYTE_LAST) begin
                    if (!rx_reg[7]) begin
                        last_r1_next = rx_reg;
                        state_next   = S_GAP;
                        case (cmd_reg)
                            C_CMD0: begin
                                if (rx_reg == 8'h01) cmd_next = C_CMD8;
                                else begin state_next = S_ERR; err_code_next = 3'd1; end
                            end
                            C_CMD8: begin
                                if (rx_reg == 8'h01) state_next = S_READ_EXT;
                                else if (rx_reg[2]) begin
                                    card_v2_next = 1'b0;
                                    cmd_next     = C_CMD55;
                                end else begin state_next = S_ERR; err_code_next = 3'd2; end
                            end
                            C_CMD55: begin
                                if (rx_reg[7:1] == 7'd0) cmd_next = C_ACMD41;
                                else begin state_next = S_ERR; err_code_next = 3'd3; end
                            end
                            C_ACMD41: begin
                                if (rx_reg == 8'h00) begin
`ifdef SD_OCR_READ_EN
                                    cmd_next   = C_CMD58;
`else
                                    state_next = S_DONE;
`endif
                                end else if (rx_reg == 8'h01) begin
                                    retry_next = retry_reg + 1'b1;
                                    if (retry_next == RT_LIMIT) begin
                                        state_next = S_ERR; err_code_next = 3'd4;
                                    end else cmd_next = C_CMD55;
                                end else begin state_next = S_ERR; err_code_next = 3'd4; end
                            end
                            default: begin
                                if (rx_reg == 8'h00) state_next = S_READ_EXT;
                                else begin state_next = S_ERR; err_code_next = 3'd6; end
                            end
                        endcase
                    end else if (byte_cnt_reg == TO_LAST) begin
                        // CMD0 silence has its own code; CMD58 silence reports its command code.
                        state_next = S_ERR;
                        case (cmd_reg)
                            C_CMD0:  err_code_next = 3'd1;
                            C_CMD58: err_code_next = 3'd6;
                            default: err_code_next = 3'd5;
                        endcase
                    end
                end
            end
            S_READ_EXT: begin
                if (fall && bit_cnt_reg == EXT_LAST) begin
                    if (cmd_reg == C_CMD8) begin
                        if (ext_reg[11:0] == 12'h1AA) begin
                            card_v2_next = 1'b1;
                            cmd_next     = C_CMD55;
                            state_next   = S_GAP;
                        end else begin state_next = S_ERR; err_code_next = 3'd2; end
                    end else begin
`ifdef SD_OCR_READ_EN
                        card_hc_next = ext_reg[30];
`endif
                        state_next   = S_DONE;
                    end
                end
            end
            S_GAP:   if (fall && bit_cnt_reg == GAP_LAST) state_next = S_SEND;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        case (cmd_next)
            C_CMD8:   frame_next = 48'h48000001AA87;
            C_CMD55:  frame_next = 48'h770000000065;
            C_ACMD41: frame_next = card_v2_next ? 48'h694000000077 : 48'h690000000001;
`ifdef SD_OCR_READ_EN
            C_CMD58:  frame_next = 48'h7A00000000FD;
`endif
            default:  frame_next = 48'h400000000095;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            div_cnt_reg  <= '0;
            sclk_reg     <= 1'b0;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            shift_reg    <= '1;
            rx_reg       <= 8'hFF;
            ext_reg      <= '0;
        end else begin
            if (!busy_int) begin
                div_cnt_reg <= '0;
                sclk_reg    <= 1'b0;
            end else if (tick) begin
                div_cnt_reg <= '0;
                sclk_reg    <= !sclk_reg;
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end

            if (rise) begin
                rx_reg  <= {rx_reg[6:0], bus.sd_miso};
                ext_reg <= {ext_reg[EXT_W-2:0], bus.sd_miso};
            end

            if (state_next != state_reg) begin
                bit_cnt_reg  <= '0;
                byte_cnt_reg <= '0;
            end else if (fall) begin
                if (state_reg == S_WAIT_R1 && bit_cnt_reg == BYTE_LAST) begin
                    bit_cnt_reg  <= '0;
                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                end else begin
                    bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                end
            end

            if (state_next == S_SEND && state_reg != S_SEND)
                shift_reg <= frame_next;
            else if (state_reg == S_SEND && fall)
                shift_reg <= {shift_reg[46:0], 1'b1};
        end
    end

    always_comb begin
        busy_int = 1'b0;
        cs_int   = 1'b1;
        mosi_int = 1'b1;
        case (state_reg)
            S_POWERUP, S_GAP: busy_int = 1'b1;
            S_SEND: begin
                busy_int = 1'b1;
                cs_int   = 1'b0;
                mosi_int = shift_reg[47];
            end
            S_WAIT_R1, S_READ_EXT: begin
                busy_int = 1'b1;
                cs_int   = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.sd_sclk  = sclk_reg;
    assign bus.sd_cs    = cs_int;
    assign bus.sd_mosi  = mosi_int;
    assign bus.busy     = busy_int;
    assign bus.done     = (state_reg == S_DONE);
    assign bus.error    = (state_reg == S_ERR);
    assign bus.err_code = err_code_reg;
    assign bus.card_v2  = card_v2_reg;
    assign bus.last_r1  = last_r1_reg;
`ifdef SD_OCR_READ_EN
    assign bus.card_hc  = card_hc_reg;
`endif
endmodule
